// File: rtl/accum_reduce_pkg.sv
// Shared constants for the accumulate/reduce output pipeline.
package accum_reduce_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_RELU = 2'd1;
    localparam logic [1:0] MODE_SAT  = 2'd2;

    // Cycles from beat acceptance to the released result entering the output buffer.
    localparam int PIPE_LATENCY = 3;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two so
// the pointers wrap for free.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/accum_reduce_pipe.sv
// Per-lane partial-sum accumulator with release, optional reduce add and
// output shaping (pass / ReLU / saturate), feeding a FWFT output buffer.
// Stage 1 registers the beat, stage 2 reads/updates the entry, stage 3 shapes
// the released result, and the FIFO takes it on the following edge.
module accum_reduce_pipe
    import accum_reduce_pkg::*;
#(
    parameter  int CHANNELS   = 4,
    parameter  int OPREC      = 32,
    parameter  int IPREC      = 8,
    parameter  int DEPTH      = 512,
    parameter  int FIFO_DEPTH = 8,
    localparam int ADDRW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [CHANNELS*OPREC-1:0] i_data,
    input  logic [ADDRW-1:0]          i_addr,
    input  logic                      i_accum,
    input  logic                      i_last,
    input  logic                      i_reduce,
    input  logic [CHANNELS*IPREC-1:0] i_rdata,
    input  logic [1:0]                i_mode,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [CHANNELS*OPREC-1:0] o_result
);

    localparam int DW = CHANNELS * OPREC;
    localparam int RW = CHANNELS * IPREC;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic signed [OPREC-1:0] SAT_HI = {{(OPREC-IPREC+1){1'b0}}, {(IPREC-1){1'b1}}};
    localparam logic signed [OPREC-1:0] SAT_LO = {{(OPREC-IPREC+1){1'b1}}, {(IPREC-1){1'b0}}};

    logic             accept;
    logic             s1_valid, s1_accum, s1_last, s1_reduce;
    logic [ADDRW-1:0] s1_addr;
    logic [DW-1:0]    s1_data;
    logic [RW-1:0]    s1_rdata;
    logic [1:0]       s1_mode;
    logic             s2_valid, s2_reduce;
    logic [DW-1:0]    s2_sum;
    logic [RW-1:0]    s2_rdata;
    logic [1:0]       s2_mode;
    logic             s3_valid;
    logic [DW-1:0]    s3_result;
    logic [DW-1:0]    acc_mem [DEPTH];
    logic [DW-1:0]    sum;
    logic [DW-1:0]    shaped;
    logic [DW-1:0]    fifo_rdata;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    free_slots;
    logic [CW-1:0]    released_inflight;

    function automatic logic [OPREC-1:0] shape_lane(
        input logic [OPREC-1:0] base,
        input logic [IPREC-1:0] r,
        input logic             add,
        input logic [1:0]       mode
    );
        logic signed [OPREC-1:0] v;
        v = $signed(base + (add ? {{(OPREC-IPREC){r[IPREC-1]}}, r} : '0));
        case (mode)
            MODE_RELU: if (v < 0) v = '0;
            MODE_SAT: begin
                if (v > SAT_HI)      v = SAT_HI;
                else if (v < SAT_LO) v = SAT_LO;
            end
            default: v = v;
        endcase
        return v;
    endfunction

    assign accept = i_valid && i_ready;

    // Room check: every released beat already in flight is guaranteed a slot.
    assign free_slots        = CW'(FIFO_DEPTH) - fifo_count;
    assign released_inflight = CW'(s1_valid && s1_last) + CW'(s2_valid) + CW'(s3_valid);
    assign i_ready           = free_slots > released_inflight;

    // Stage 1: register the accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_accum  <= 1'b0;
            s1_last   <= 1'b0;
            s1_reduce <= 1'b0;
            s1_addr   <= '0;
            s1_data   <= '0;
            s1_rdata  <= '0;
            s1_mode   <= MODE_PASS;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_accum  <= i_accum;
                s1_last   <= i_last;
                s1_reduce <= i_reduce;
                s1_addr   <= i_addr;
                s1_data   <= i_data;
                s1_rdata  <= i_rdata;
                s1_mode   <= i_mode;
            end
        end
    end

    // Stage 2 sum; the entry is read after the previous beat's write landed,
    // so back-to-back beats to one address see the in-flight sum directly.
    always_comb begin
        sum = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum[k*OPREC +: OPREC] = (s1_accum ? acc_mem[s1_addr][k*OPREC +: OPREC] : '0)
                                  + s1_data[k*OPREC +: OPREC];
        end
    end

    // Accumulation memory update: last beat clears the entry.
    always_ff @(posedge clk) begin
        if (s1_valid) acc_mem[s1_addr] <= s1_last ? '0 : sum;
    end

    // Stage 2 registers: only released beats continue downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_reduce <= 1'b0;
            s2_sum    <= '0;
            s2_rdata  <= '0;
            s2_mode   <= MODE_PASS;
        end else begin
            s2_valid  <= s1_valid && s1_last;
            s2_reduce <= s1_reduce;
            s2_sum    <= sum;
            s2_rdata  <= s1_rdata;
            s2_mode   <= s1_mode;
        end
    end

    // Stage 3 shaping per lane.
    always_comb begin
        shaped = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            shaped[k*OPREC +: OPREC] = shape_lane(s2_sum[k*OPREC +: OPREC],
                                                  s2_rdata[k*IPREC +: IPREC],
                                                  s2_reduce, s2_mode);
        end
    end

    // Stage 3 registers feeding the output buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_valid  <= 1'b0;
            s3_result <= '0;
        end else begin
            s3_valid  <= s2_valid;
            s3_result <= shaped;
        end
    end

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (s3_valid),
        .wdata (s3_result),
        .pop   (o_valid && o_ready),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign o_valid  = !fifo_empty;
    assign o_result = fifo_empty ? '0 : fifo_rdata;

endmodule

// File: tb/tb_accum_reduce_pipe.sv
// Randomized and directed bench for accum_reduce_pipe against a serial
// accumulate/release model with a timed expected-output queue.
module tb_accum_reduce_pipe;
    import accum_reduce_pkg::*;

    localparam int CH = 4;
    localparam int OP = 32;
    localparam int IP = 8;
    localparam int DEP = 512;
    localparam int FD = 8;
    localparam int AW = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             i_ready;
    logic [CH*OP-1:0] i_data;
    logic [AW-1:0]    i_addr;
    logic             i_accum;
    logic             i_last;
    logic             i_reduce;
    logic [CH*IP-1:0] i_rdata;
    logic [1:0]       i_mode;
    logic             o_valid;
    logic             o_ready;
    logic [CH*OP-1:0] o_result;

    always #5 clk = ~clk;

    accum_reduce_pipe #(
        .CHANNELS   (CH),
        .OPREC      (OP),
        .IPREC      (IP),
        .DEPTH      (DEP),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .i_addr   (i_addr),
        .i_accum  (i_accum),
        .i_last   (i_last),
        .i_reduce (i_reduce),
        .i_rdata  (i_rdata),
        .i_mode   (i_mode),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_result (o_result)
    );

    typedef struct {
        logic [CH*OP-1:0] res;
        int               ready_at;
    } exp_t;

    exp_t             exp_q[$];
    logic [OP-1:0]    ref_acc [DEP][CH];
    bit               ref_ok [DEP];
    int               n_tests = 0;
    int               n_fail = 0;
    int               cyc = 0;
    logic [CH*OP-1:0] last_out = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [OP-1:0] ref_shape(input int v, input logic [1:0] m);
        int r = v;
        if (m == 2'd1 && v < 0) r = 0;
        if (m == 2'd2) begin
            if (v > 127)       r = 127;
            else if (v < -128) r = -128;
        end
        return OP'(r);
    endfunction

    // Serial semantics: each accepted beat fully updates the entry before the next.
    task automatic ref_accept();
        exp_t          e;
        logic [OP-1:0] s;
        int            r;
        e.res = '0;
        for (int k = 0; k < CH; k++) begin
            s = (i_accum ? ref_acc[i_addr][k] : 32'd0) + i_data[k*OP +: OP];
            if (i_last) begin
                ref_acc[i_addr][k] = 32'd0;
                r = int'(s) + (i_reduce ? int'($signed(i_rdata[k*IP +: IP])) : 0);
                e.res[k*OP +: OP] = ref_shape(r, i_mode);
            end else begin
                ref_acc[i_addr][k] = s;
            end
        end
        ref_ok[i_addr] = 1'b1;
        if (i_last) begin
            e.ready_at = cyc + PIPE_LATENCY + 1;
            exp_q.push_back(e);
        end
    endtask

    // Called at a falling edge: check outputs, model the coming rising edge, advance.
    task automatic step();
        int in_fifo = 0;
        bit exp_v;
        foreach (exp_q[j]) if (exp_q[j].ready_at <= cyc) in_fifo++;
        exp_v = (in_fifo > 0);
        chk("o_valid", o_valid, exp_v);
        chk("i_ready", i_ready, (FD - in_fifo) > (exp_q.size() - in_fifo));
        if (exp_v) chk("o_result", o_result, exp_q[0].res);
        if (o_valid && o_ready) begin
            last_out = o_result;
            if (exp_v) exp_q.delete(0);
        end
        if (i_valid && i_ready && rst) ref_accept();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [OP-1:0] d, input logic acc,
                        input logic last, input logic red, input logic [IP-1:0] rd,
                        input logic [1:0] m);
        int budget = 0;
        i_valid = 1'b1; i_addr = a; i_data = {CH{d}}; i_accum = acc; i_last = last;
        i_reduce = red; i_rdata = {CH{rd}}; i_mode = m;
        while (!i_ready && budget < 50) begin
            step();
            budget++;
        end
        if (!i_ready) chk("send_timeout", i_ready, 1'b1);
        step();
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        int b = 0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        while (exp_q.size() > 0 && b < 200) begin
            step();
            b++;
        end
        chk("drain_empty", exp_q.size(), 0);
        step();
    endtask

    function automatic logic [OP-1:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
            default: return 32'($urandom_range(0, 600)) - 32'd300;
        endcase
    endfunction

    initial begin
        int c0;
        int sent;
        rst = 1'b0;
        i_valid = 1'b0; i_data = '0; i_addr = '0; i_accum = 1'b0; i_last = 1'b0;
        i_reduce = 1'b0; i_rdata = '0; i_mode = 2'd0; o_ready = 1'b1;
        foreach (ref_ok[j]) ref_ok[j] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_result", o_result, '0);
        rst = 1'b1;
        step();

        // Three-beat accumulation, release on the third
        send(9'd5, 32'd10, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        send(9'd5, 32'd20, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
        send(9'd5, 32'd30, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
        drain();
        chk("sum3", last_out, {CH{32'd60}});

        // Back-to-back beats to one address, no bubbles
        c0 = cyc;
        send(9'd7, 32'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        send(9'd7, 32'd1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
        send(9'd7, 32'd1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
        send(9'd7, 32'd1, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
        chk("fwd_cycles", cyc - c0, 4);
        drain();
        chk("fwd4", last_out, {CH{32'd4}});

        // Reduce add and output modes
        send(9'd9, 32'd300, 1'b0, 1'b1, 1'b1, 8'hCE, 2'd2);
        drain();
        chk("sat_hi", last_out, {CH{32'd127}});
        send(9'd10, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0, 8'd0, 2'd1);
        drain();
        chk("relu_neg", last_out, {CH{32'd0}});
        send(9'd11, 32'hFFFF_FF38, 1'b0, 1'b1, 1'b0, 8'd0, 2'd2);
        drain();
        chk("sat_lo", last_out, {CH{32'hFFFF_FF80}});
        send(9'd12, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        send(9'd12, 32'd1, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
        drain();
        chk("wrap", last_out, {CH{32'h8000_0000}});

        // Backpressure: 12 released beats against a stalled consumer
        o_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 30; c++) begin
            bit acc_now;
            i_valid = (sent < 12);
            i_addr = AW'(20 + sent); i_data = {CH{32'(100 + sent)}};
            i_accum = 1'b0; i_last = 1'b1; i_reduce = 1'b0; i_mode = 2'd0;
            acc_now = i_valid && i_ready;
            step();
            if (acc_now) sent++;
        end
        chk("stall_count", sent, 8);
        chk("stall_ready", i_ready, 1'b0);
        chk("stall_valid", o_valid, 1'b1);
        o_ready = 1'b1;
        for (int c = 0; c < 100 && (sent < 12 || exp_q.size() > 0); c++) begin
            bit acc_now;
            i_valid = (sent < 12);
            i_addr = AW'(20 + sent); i_data = {CH{32'(100 + sent)}};
            acc_now = i_valid && i_ready;
            step();
            if (acc_now) sent++;
        end
        chk("stall_sent", sent, 12);
        drain();
        chk("stall_last", last_out, {CH{32'd111}});

        // Reset in the middle of an accumulation with outputs queued
        o_ready = 1'b0;
        send(9'd1, 32'd41, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
        send(9'd2, 32'd42, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
        send(9'd3, 32'd5, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        send(9'd3, 32'd6, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
        idle(5);
        rst = 1'b0;
        #1;
        chk("midrst_o_valid", o_valid, 1'b0);
        chk("midrst_o_result", o_result, '0);
        exp_q.delete();
        foreach (ref_ok[j]) ref_ok[j] = 1'b0;
        step();
        step();
        rst = 1'b1;
        o_ready = 1'b1;
        idle(6);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            for (int k = 0; k < CH; k++) begin
                i_data[k*OP +: OP] = rnd_word();
                i_rdata[k*IP +: IP] = IP'($urandom);
            end
            i_accum = ref_ok[i_addr] ? 1'($urandom) : 1'b0;
            i_last = ($urandom_range(0, 2) == 0);
            i_reduce = 1'($urandom);
            i_mode = 2'($urandom);
            o_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
